// File: rtl/iw_pkg.sv
// Shared types for the instruction-word sequencer: opcode and FSM state encodings
// plus the field layout of an instruction word {opcode, operand}.
package iw_pkg;

    localparam int IW_N  = 6;
    localparam int OPC_W = 2;

    // Field slices of an instruction word for an operand width of IW_N
    localparam int OPND_LSB = 0;
    localparam int OPND_MSB = IW_N - 1;
    localparam int OPC_LSB  = IW_N;
    localparam int OPC_MSB  = IW_N + OPC_W - 1;

    typedef enum logic [OPC_W-1:0] {
        OP_NOP  = 2'b00,
        OP_PIM  = 2'b01,
        OP_MOV  = 2'b10,
        OP_HALT = 2'b11
    } opcode_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RUN    = 3'd2,
        MOVE   = 3'd3,
        HALTED = 3'd4
    } seq_state_e;

endpackage

// File: rtl/iw_fifo.sv
// Small instruction FIFO with extra-MSB pointers; clear has priority over push/pop
// and a write into a full FIFO is dropped even if a pop happens in the same cycle.
module iw_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr_q;
    logic [AW:0]  rd_ptr_q;
    logic [W-1:0] mem_q [DEPTH];
    logic         do_push;
    logic         do_pop;

    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/iw_sequencer.sv
// Instruction-word sequencer: buffers PIM/MOV/HALT words and drives the iw register strobes.
// Optional build macro IW_SEQ_STALL_CNT_EN adds a saturating stall_cnt output.
module iw_sequencer
    import iw_pkg::*;
#(
    parameter  int N       = 6,
    parameter  int DEPTH   = 4,
    localparam int INSTR_W = N + 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic               flush,
    input  logic               resume,
    input  logic [N-1:0]       iw_Q,
    output logic [N-1:0]       iw_D,
    output logic [N-1:0]       iw_MOV_in,
    output logic               PIM_load,
    output logic               Update_load,
    output logic               Mov_load,
    output logic               pim_step,
    output logic               busy,
    output logic               halted
`ifdef IW_SEQ_STALL_CNT_EN
    ,
    output logic [15:0]        stall_cnt
`endif
);

    seq_state_e         state_q;
    seq_state_e         state_d;
    logic [N-1:0]       pim_cnt_q;
    logic [N-1:0]       mov_val_q;
    logic [INSTR_W-1:0] head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;
    opcode_e            head_op;
    logic [N-1:0]       head_opnd;

    assign head_op     = opcode_e'(head[INSTR_W-1 -: OPC_W]);
    assign head_opnd   = head[N-1:0];
    assign instr_ready = !fifo_full;
    assign pop         = (state_q == IDLE) && !fifo_empty && !flush;

    iw_fifo #(.W(INSTR_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (flush),
        .push  (instr_valid),
        .wdata (instr_in),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        case (head_op)
                            OP_PIM:  state_d = (head_opnd != '0) ? LOAD : IDLE;
                            OP_MOV:  state_d = MOVE;
                            OP_HALT: state_d = HALTED;
                            default: state_d = IDLE;
                        endcase
                    end
                end
                LOAD:    state_d = RUN;
                // Leave on the last iteration (count 1) or if the count is already exhausted
                RUN:     if ((iw_Q == N'(1)) || (iw_Q == '0)) state_d = IDLE;
                MOVE:    state_d = IDLE;
                HALTED:  if (resume) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        PIM_load    = 1'b0;
        Update_load = 1'b0;
        Mov_load    = 1'b0;
        pim_step    = 1'b0;
        case (state_q)
            LOAD: PIM_load = 1'b1;
            RUN: begin
                if (iw_Q != '0) begin
                    Update_load = 1'b1;
                    pim_step    = 1'b1;
                end
            end
            MOVE:    Mov_load = 1'b1;
            default: ;
        endcase
    end

    assign halted = (state_q == HALTED);
    assign busy   = (state_q != IDLE) || !fifo_empty;

    // Operands are captured at the pop edge so they are stable while the strobe is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pim_cnt_q <= '0;
            mov_val_q <= '0;
        end else if (pop) begin
            if (head_op == OP_PIM) pim_cnt_q <= head_opnd;
            if (head_op == OP_MOV) mov_val_q <= head_opnd;
        end
    end

    assign iw_D      = pim_cnt_q;
    assign iw_MOV_in = mov_val_q;

`ifdef IW_SEQ_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt_q <= '0;
        else if (flush)
            stall_cnt_q <= '0;
        else if (instr_valid && fifo_full && (stall_cnt_q != 16'hFFFF))
            stall_cnt_q <= stall_cnt_q + 16'd1;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_iw_sequencer.sv
// Self-checking bench for iw_sequencer: directed vector table, multi-cycle corner
// sequences and a randomized run against a queue-based reference model.
module tb_iw_sequencer;
    import iw_pkg::*;

    localparam int N     = 6;
    localparam int DEPTH = 4;
    localparam int IW    = N + 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [IW-1:0] instr_in = '0;
    logic          instr_valid = 1'b0;
    logic          flush = 1'b0;
    logic          resume = 1'b0;
    logic [N-1:0]  iw_Q;
    logic          instr_ready;
    logic [N-1:0]  iw_D;
    logic [N-1:0]  iw_MOV_in;
    logic          PIM_load, Update_load, Mov_load, pim_step, busy, halted;
`ifdef IW_SEQ_STALL_CNT_EN
    logic [15:0]   stall_cnt;
`endif

    int errors = 0;
    int checks = 0;

    iw_sequencer #(.N(N), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_in    (instr_in),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .flush       (flush),
        .resume      (resume),
        .iw_Q        (iw_Q),
        .iw_D        (iw_D),
        .iw_MOV_in   (iw_MOV_in),
        .PIM_load    (PIM_load),
        .Update_load (Update_load),
        .Mov_load    (Mov_load),
        .pim_step    (pim_step),
        .busy        (busy),
        .halted      (halted)
`ifdef IW_SEQ_STALL_CNT_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural iw register driven by the sequencer strobes
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)          iw_Q <= '0;
        else if (PIM_load)   iw_Q <= iw_D;
        else if (Update_load) iw_Q <= iw_Q - 1'b1;
        else if (Mov_load)   iw_Q <= iw_MOV_in;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [IW-1:0] mk(input logic [1:0] op, input logic [N-1:0] v);
        return {op, v};
    endfunction

    task automatic push_one(input logic [IW-1:0] w);
        instr_in    = w;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
    endtask

    task automatic do_reset();
        instr_valid = 1'b0;
        flush       = 1'b0;
        resume      = 1'b0;
        rst_n       = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    typedef struct {
        logic [IW-1:0] a;
        logic [IW-1:0] b;
        int            pl;
        int            steps;
        int            ml;
        logic [N-1:0]  d;
        logic [N-1:0]  mov;
        logic [N-1:0]  q;
    } vec_t;

    // Expected strobe pattern for PIM c=3 sampled after each edge following the push
    typedef struct {
        logic pl, ul, st, bz;
    } cyc_t;

    initial begin
        vec_t tbl[8];
        cyc_t pim3[6];
        logic [IW-1:0] mq[$];
        int sched[$];
        bit m_halt;
        logic [N-1:0] m_d, m_mov;
        int m_stall;

        tbl[0] = '{mk(2'b01, 6'd3),  mk(2'b00, 6'd0), 1, 3,  0, 6'd3,  6'd0,  6'd0};
        tbl[1] = '{mk(2'b01, 6'd0),  mk(2'b10, 6'h2A), 0, 0, 1, 6'd0,  6'h2A, 6'h2A};
        tbl[2] = '{mk(2'b00, 6'd9),  mk(2'b00, 6'd0), 0, 0,  0, 6'd0,  6'd0,  6'h2A};
        tbl[3] = '{mk(2'b01, 6'd1),  mk(2'b00, 6'd0), 1, 1,  0, 6'd1,  6'd0,  6'd0};
        tbl[4] = '{mk(2'b10, 6'h15), mk(2'b00, 6'd0), 0, 0,  1, 6'd0,  6'h15, 6'h15};
        tbl[5] = '{mk(2'b01, 6'd0),  mk(2'b00, 6'd0), 0, 0,  0, 6'd0,  6'd0,  6'h15};
        tbl[6] = '{mk(2'b01, 6'd63), mk(2'b00, 6'd0), 1, 63, 0, 6'd63, 6'd0,  6'd0};
        tbl[7] = '{mk(2'b01, 6'd2),  mk(2'b10, 6'h3F), 1, 2, 1, 6'd2,  6'h3F, 6'h3F};

        pim3[0] = '{0, 0, 0, 1};
        pim3[1] = '{1, 0, 0, 1};
        pim3[2] = '{0, 1, 1, 1};
        pim3[3] = '{0, 1, 1, 1};
        pim3[4] = '{0, 1, 1, 1};
        pim3[5] = '{0, 0, 0, 0};

        // Reset state, observed while rst_n is still low
        tick();
        tick();
        chk("rst_strobes", {PIM_load, Update_load, Mov_load, pim_step}, 4'b0);
        chk("rst_busy_halted", {busy, halted}, 2'b0);
        chk("rst_ready", instr_ready, 1'b1);
        chk("rst_iw_d_mov", {iw_D, iw_MOV_in}, '0);
        rst_n = 1'b1;
        tick();

        // Table: each entry is one or two pushed words, run to completion
        for (int i = 0; i < 8; i++) begin
            int n_pl, n_st, n_ml, n_multi, n_ul_mismatch;
            logic [N-1:0] cap_d, cap_mov;
            bit done;
            n_pl = 0; n_st = 0; n_ml = 0; n_multi = 0; n_ul_mismatch = 0;
            cap_d = '0; cap_mov = '0; done = 0;
            instr_in = tbl[i].a; instr_valid = 1'b1; tick();
            instr_in = tbl[i].b; tick();
            instr_valid = 1'b0;
            for (int c = 0; c < 150 && !done; c++) begin
                if (PIM_load) begin n_pl++; cap_d = iw_D; end
                if (Mov_load) begin n_ml++; cap_mov = iw_MOV_in; end
                if (pim_step) n_st++;
                if (pim_step != Update_load) n_ul_mismatch++;
                if (32'(PIM_load) + 32'(Update_load) + 32'(Mov_load) > 1) n_multi++;
                if (!busy) done = 1;
                else tick();
            end
            chk($sformatf("t%0d_done", i), done, 1'b1);
            chk($sformatf("t%0d_pim_load", i), n_pl, tbl[i].pl);
            chk($sformatf("t%0d_steps", i), n_st, tbl[i].steps);
            chk($sformatf("t%0d_mov_load", i), n_ml, tbl[i].ml);
            chk($sformatf("t%0d_ul_eq_step", i), n_ul_mismatch, 0);
            chk($sformatf("t%0d_one_strobe", i), n_multi, 0);
            if (tbl[i].pl > 0) chk($sformatf("t%0d_iw_D", i), cap_d, tbl[i].d);
            if (tbl[i].ml > 0) chk($sformatf("t%0d_iw_MOV_in", i), cap_mov, tbl[i].mov);
            chk($sformatf("t%0d_iw_Q", i), iw_Q, tbl[i].q);
            $display("vector %0d: a=%h b=%h pl=%0d steps=%0d ml=%0d", i, tbl[i].a, tbl[i].b, n_pl, n_st, n_ml);
        end

        // Cycle-exact PIM c=3
        do_reset();
        instr_in = mk(2'b01, 6'd3); instr_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            instr_valid = 1'b0;
            chk($sformatf("p3_c%0d_pl", k), PIM_load, pim3[k].pl);
            chk($sformatf("p3_c%0d_ul", k), Update_load, pim3[k].ul);
            chk($sformatf("p3_c%0d_step", k), pim_step, pim3[k].st);
            chk($sformatf("p3_c%0d_busy", k), busy, pim3[k].bz);
            if (pim3[k].pl) chk("p3_iw_D", iw_D, 6'd3);
        end
        chk("p3_iw_Q_end", iw_Q, 6'd0);
        $display("sequence pim3 done");

        // HALTED: fill FIFO, overflow attempts, resume preserves order
        begin
            logic [N-1:0] got[$];
            push_one(mk(2'b11, 6'd0));
            tick();
            chk("halt_halted", halted, 1'b1);
            for (int i = 1; i <= 4; i++) begin
                chk($sformatf("halt_ready%0d", i), instr_ready, 1'b1);
                instr_in = mk(2'b10, N'(i)); instr_valid = 1'b1;
                tick();
            end
            instr_in = mk(2'b10, 6'd5);
            chk("halt_ready5", instr_ready, 1'b0);
            for (int i = 0; i < 7; i++) tick();
            instr_valid = 1'b0;
            chk("halt_still_halted", halted, 1'b1);
`ifdef IW_SEQ_STALL_CNT_EN
            chk("stall_cnt_7", stall_cnt, 16'd7);
`endif
            resume = 1'b1; tick(); resume = 1'b0;
            chk("resume_halted", halted, 1'b0);
            for (int c = 0; c < 40 && busy; c++) begin
                if (Mov_load) got.push_back(iw_MOV_in);
                tick();
            end
            chk("order_busy_end", busy, 1'b0);
            chk("order_count", got.size(), 4);
            for (int i = 0; i < got.size() && i < 4; i++)
                chk($sformatf("order_%0d", i), got[i], N'(i + 1));
`ifdef IW_SEQ_STALL_CNT_EN
            chk("stall_cnt_held", stall_cnt, 16'd7);
            flush = 1'b1; tick(); flush = 1'b0;
            chk("stall_cnt_flush", stall_cnt, 16'd0);
`endif
            $display("sequence halt/full: %0d MOVs retired", got.size());
        end

        // flush during RUN with a simultaneous push
        begin
            int n_st, n_any;
            n_st = 0; n_any = 0;
            push_one(mk(2'b01, 6'd10));
            for (int c = 0; c < 30 && n_st < 4; c++) begin
                tick();
                if (pim_step) n_st++;
            end
            chk("flush_pre_steps", n_st, 4);
            flush = 1'b1; instr_valid = 1'b1; instr_in = mk(2'b10, 6'd7);
            tick();
            flush = 1'b0; instr_valid = 1'b0;
            chk("flush_strobes", {PIM_load, Update_load, Mov_load, pim_step}, 4'b0);
            chk("flush_busy", busy, 1'b0);
            chk("flush_ready", instr_ready, 1'b1);
            for (int c = 0; c < 20; c++) begin
                tick();
                if (PIM_load || Update_load || Mov_load || pim_step) n_any++;
            end
            chk("flush_push_lost", n_any, 0);
            $display("sequence flush-in-RUN done");
        end

        // Asynchronous reset mid-RUN
        begin
            int n_st;
            n_st = 0;
            push_one(mk(2'b01, 6'd5));
            for (int c = 0; c < 30 && n_st < 2; c++) begin
                tick();
                if (pim_step) n_st++;
            end
            chk("arst_pre_steps", n_st, 2);
            #2 rst_n = 1'b0;
            #1;
            chk("arst_strobes", {PIM_load, Update_load, Mov_load, pim_step}, 4'b0);
            chk("arst_busy_halted", {busy, halted}, 2'b0);
            chk("arst_ready", instr_ready, 1'b1);
            chk("arst_iw_d_mov", {iw_D, iw_MOV_in}, '0);
            @(negedge clk);
            rst_n = 1'b1;
            n_st = 0;
            for (int c = 0; c < 20; c++) begin
                tick();
                if (pim_step) n_st++;
            end
            chk("arst_no_steps", n_st, 0);
            $display("sequence async reset done");
        end

        // Randomized run against a schedule-queue reference model
        do_reset();
        m_halt = 0; m_d = '0; m_mov = '0; m_stall = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            int code;
            bit v, f, r, can_push;
            logic [1:0] op;
            logic [N-1:0] opnd;
            logic [IW-1:0] w;
            code = (sched.size() > 0) ? sched[0] : 0;
            chk("r_pim_load", PIM_load, code == 1);
            chk("r_step", pim_step, code == 2);
            chk("r_update", Update_load, code == 2);
            chk("r_mov_load", Mov_load, code == 3);
            chk("r_halted", halted, m_halt);
            chk("r_busy", busy, (sched.size() > 0) || m_halt || (mq.size() > 0));
            chk("r_ready", instr_ready, mq.size() < DEPTH);
            chk("r_iw_D", iw_D, m_d);
            chk("r_iw_MOV_in", iw_MOV_in, m_mov);
`ifdef IW_SEQ_STALL_CNT_EN
            chk("r_stall_cnt", stall_cnt, m_stall[15:0]);
`endif
            v  = ($urandom_range(0, 99) < 60);
            f  = ($urandom_range(0, 99) < 3);
            r  = ($urandom_range(0, 99) < 20);
            op = 2'($urandom_range(0, 3));
            opnd = (op == 2'b01) ? N'($urandom_range(0, 4)) : N'($urandom_range(0, 63));
            w = {op, opnd};
            instr_in = w; instr_valid = v; flush = f; resume = r;
            if (f) begin
                mq.delete(); sched.delete(); m_halt = 0; m_stall = 0;
            end else begin
                can_push = (mq.size() < DEPTH);
                if (v && !can_push && m_stall < 65535) m_stall++;
                if (m_halt) begin
                    if (r) m_halt = 0;
                end else if (sched.size() > 0) begin
                    void'(sched.pop_front());
                end else if (mq.size() > 0) begin
                    logic [IW-1:0] h;
                    h = mq.pop_front();
                    case (h[IW-1:N])
                        2'b01: begin
                            m_d = h[N-1:0];
                            if (h[N-1:0] != 0) begin
                                sched.push_back(1);
                                for (int s = 0; s < int'(h[N-1:0]); s++) sched.push_back(2);
                            end
                        end
                        2'b10: begin m_mov = h[N-1:0]; sched.push_back(3); end
                        2'b11: m_halt = 1;
                        default: ;
                    endcase
                end
                if (v && can_push) mq.push_back(w);
            end
            tick();
        end
        instr_valid = 1'b0; flush = 1'b0; resume = 1'b0;
        $display("random phase done: 800 cycles");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
